// File: rtl/gs_pkg.sv
// Shared decode-stage types: opcodes, ALU codes, immediate kinds,
// the decoded control bundle and the decode-stage FSM states.
package gs_pkg;

    typedef enum logic [6:0] {
        OPC_LOAD   = 7'b0000011,
        OPC_OP_IMM = 7'b0010011,
        OPC_AUIPC  = 7'b0010111,
        OPC_STORE  = 7'b0100011,
        OPC_OP     = 7'b0110011,
        OPC_LUI    = 7'b0110111,
        OPC_BRANCH = 7'b1100011,
        OPC_JALR   = 7'b1100111,
        OPC_JAL    = 7'b1101111
    } gs_opcode_e;

    localparam logic [3:0] ALU_PLUS    = 4'b0000;
    localparam logic [3:0] ALU_FORWARD = 4'b1011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } gs_imm_type_e;

    typedef struct packed {
        gs_imm_type_e imm_type;
        logic [31:0]  imm;
        logic [3:0]   alu_type;
        logic [1:0]   pc_src;
        logic         pc_to_reg;
        logic         mem_write;
        logic         mem_read;
        logic         rd_src;
        logic         mem_to_reg;
        logic         alu_src;
        logic         reg_write;
        logic [2:0]   data_size;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [4:0]   rd;
        logic         illegal;
    } gs_dec_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } gs_dec_state_e;

endpackage

// File: rtl/gs_imm_gen.sv
// Immediate generator: builds the sign-extended RV32I immediate.
// Ports: instr[31:7] (opcode bits not needed), imm_type in, imm out.
module gs_imm_gen
    import gs_pkg::*;
(
    input  logic [31:7]  instr,
    input  gs_imm_type_e imm_type,
    output logic [31:0]  imm
);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7],
                          instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12],
                          instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/gs_decode_stage.sv
// Buffered RV32I decode stage: fetch queue, decoder, output register.
// Ports: clk/rst (sync, active-low), flush_i, fetch valid/ready/pc/instr,
// decode valid/ready, id_pc_o, id_dec_o bundle.
module gs_decode_stage
    import gs_pkg::*;
#(
    parameter int QDEPTH          = 4,
    parameter int PC_W            = 32,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [PC_W-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [PC_W-1:0] id_pc_o,
    output gs_dec_t         id_dec_o
);

    localparam int AW = $clog2(QDEPTH);
    localparam bit HALT_EN = (HALT_ON_ILLEGAL != 0);

    logic [AW:0]      wptr, rptr;
    logic [PC_W-1:0]  q_pc  [QDEPTH];
    logic [31:0]      q_ins [QDEPTH];
    logic             q_full, q_empty, push, load, halt_ev;
    logic [PC_W-1:0]  head_pc;
    logic [31:0]      head_ins;
    logic [6:0]       opc, f7;
    logic [2:0]       f3;
    logic [31:0]      imm;
    logic             ill;
    gs_dec_t          dc, dec_n;
    gs_dec_state_e    state, state_n;

    // Wrap bit distinguishes full from empty when indices match
    assign q_full  = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign q_empty = (wptr == rptr);

    assign if_ready_o = rst & ~q_full & (state == ST_RUN);
    assign push       = if_valid_i & if_ready_o;
    assign load       = ~q_empty & (~id_valid_o | id_ready_i);
    assign halt_ev    = HALT_EN & load & dec_n.illegal;

    assign head_pc  = q_pc[rptr[AW-1:0]];
    assign head_ins = q_ins[rptr[AW-1:0]];
    assign opc      = head_ins[6:0];
    assign f3       = head_ins[14:12];
    assign f7       = head_ins[31:25];

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wptr[AW-1:0]]  <= if_pc_i;
            q_ins[wptr[AW-1:0]] <= if_instr_i;
        end
    end

    // Halting on an illegal word also drops everything queued behind it
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush_i || halt_ev) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + (AW+1)'(1);
            if (load) rptr <= rptr + (AW+1)'(1);
        end
    end

    always_comb begin
        dc     = '0;
        ill    = 1'b0;
        dc.rs1 = head_ins[19:15];
        dc.rs2 = head_ins[24:20];
        dc.rd  = head_ins[11:7];
        case (opc)
            OPC_OP: begin
                dc.alu_type  = {f7[5], f3};
                dc.alu_src   = 1'b1;
                dc.reg_write = 1'b1;
                if (f7 != 7'h00 && f7 != 7'h20) ill = 1'b1;
                if (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101)
                    ill = 1'b1;
            end
            OPC_OP_IMM: begin
                dc.imm_type  = IMM_I;
                dc.alu_type  = {(f3 == 3'b101) ? f7[5] : 1'b0, f3};
                dc.reg_write = 1'b1;
                if (f3 == 3'b001 && f7 != 7'h00) ill = 1'b1;
                if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
                    ill = 1'b1;
            end
            OPC_LOAD: begin
                dc.imm_type   = IMM_I;
                dc.alu_type   = ALU_PLUS;
                dc.mem_read   = 1'b1;
                dc.mem_to_reg = 1'b1;
                dc.reg_write  = 1'b1;
                dc.data_size  = f3;
                if (f3 == 3'b011 || f3[2:1] == 2'b11) ill = 1'b1;
            end
            OPC_STORE: begin
                dc.imm_type  = IMM_S;
                dc.alu_type  = ALU_PLUS;
                dc.mem_write = 1'b1;
                dc.data_size = f3;
                if (f3[2] || f3 == 3'b011) ill = 1'b1;
            end
            OPC_BRANCH: begin
                dc.imm_type = IMM_B;
                dc.alu_type = {1'b1, f3};
                dc.pc_src   = 2'b11;
                if (f3[2:1] == 2'b01) ill = 1'b1;
            end
            OPC_JALR: begin
                dc.imm_type  = IMM_I;
                dc.alu_type  = ALU_PLUS;
                dc.pc_src    = 2'b10;
                dc.rd_src    = 1'b1;
                dc.reg_write = 1'b1;
                if (f3 != 3'b000) ill = 1'b1;
            end
            OPC_JAL: begin
                dc.imm_type  = IMM_J;
                dc.alu_type  = ALU_FORWARD;
                dc.pc_src    = 2'b01;
                dc.rd_src    = 1'b1;
                dc.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dc.imm_type  = IMM_U;
                dc.pc_to_reg = 1'b1;
                dc.rd_src    = 1'b1;
                dc.reg_write = 1'b1;
            end
            OPC_LUI: begin
                dc.imm_type  = IMM_U;
                dc.alu_type  = ALU_FORWARD;
                dc.reg_write = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        if (head_ins[1:0] != 2'b11) ill = 1'b1;
    end

    gs_imm_gen u_imm_gen (
        .instr    (head_ins[31:7]),
        .imm_type (dc.imm_type),
        .imm      (imm)
    );

    // An illegal bundle carries no side effects, only the flag
    always_comb begin
        dec_n     = dc;
        dec_n.imm = imm;
        if (ill) begin
            dec_n         = '0;
            dec_n.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= ST_RUN;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (flush_i)      state_n = ST_RUN;
        else if (halt_ev) state_n = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            id_valid_o <= 1'b0;
            id_pc_o    <= '0;
            id_dec_o   <= '0;
        end else if (flush_i) begin
            id_valid_o <= 1'b0;
        end else if (load) begin
            id_valid_o <= 1'b1;
            id_pc_o    <= head_pc;
            id_dec_o   <= dec_n;
        end else if (id_ready_i) begin
            id_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gs_decode_stage.sv
// Testbench for gs_decode_stage: decode vector table, queue capacity,
// illegal halt and flush sequences checked through a scoreboard.
module tb_gs_decode_stage;
    import gs_pkg::*;

    localparam int PC_W = 32;

    typedef struct {
        logic [31:0] instr;
        gs_dec_t     exp;
    } vec_t;

    typedef struct {
        logic [PC_W-1:0] pc;
        gs_dec_t         dec;
    } sb_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush_i;
    logic            if_valid_i;
    logic            if_ready_o;
    logic [PC_W-1:0] if_pc_i;
    logic [31:0]     if_instr_i;
    logic            id_valid_o;
    logic            id_ready_i;
    logic [PC_W-1:0] id_pc_o;
    gs_dec_t         id_dec_o;

    int      errors = 0;
    int      checks = 0;
    int      pops   = 0;
    vec_t    tbl [17];
    sb_t     sb [$];
    gs_dec_t drv_exp;

    gs_decode_stage #(.QDEPTH(4), .PC_W(PC_W), .HALT_ON_ILLEGAL(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush_i),
        .if_valid_i (if_valid_i),
        .if_ready_o (if_ready_o),
        .if_pc_i    (if_pc_i),
        .if_instr_i (if_instr_i),
        .id_valid_o (id_valid_o),
        .id_ready_i (id_ready_i),
        .id_pc_o    (id_pc_o),
        .id_dec_o   (id_dec_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // flags: pc_to_reg,mem_write,mem_read,rd_src,mem_to_reg,alu_src,reg_write
    function automatic vec_t mk(input logic [31:0] ins,
                                input gs_imm_type_e it,
                                input logic [31:0] imm,
                                input logic [3:0] alu,
                                input logic [1:0] pcs,
                                input logic [6:0] fl,
                                input logic [2:0] ds);
        vec_t v;
        v.instr            = ins;
        v.exp              = '0;
        v.exp.imm_type     = it;
        v.exp.imm          = imm;
        v.exp.alu_type     = alu;
        v.exp.pc_src       = pcs;
        v.exp.pc_to_reg    = fl[6];
        v.exp.mem_write    = fl[5];
        v.exp.mem_read     = fl[4];
        v.exp.rd_src       = fl[3];
        v.exp.mem_to_reg   = fl[2];
        v.exp.alu_src      = fl[1];
        v.exp.reg_write    = fl[0];
        v.exp.data_size    = ds;
        v.exp.rs1          = ins[19:15];
        v.exp.rs2          = ins[24:20];
        v.exp.rd           = ins[11:7];
        return v;
    endfunction

    function automatic vec_t mkill(input logic [31:0] ins);
        vec_t v;
        v.instr       = ins;
        v.exp         = '0;
        v.exp.illegal = 1'b1;
        return v;
    endfunction

    // Scoreboard: push on accepted fetch word, pop on decode handshake
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (id_valid_o === 1'b1 && id_ready_i === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bundle: got pc 0x%0h, expected none",
                             id_pc_o);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    pops++;
                    chk("out_pc", id_pc_o, e.pc);
                    if (e.dec.illegal) begin
                        chk("illegal_bundle",
                            {id_dec_o.illegal, id_dec_o.reg_write,
                             id_dec_o.mem_write, id_dec_o.mem_read,
                             id_dec_o.pc_src, id_dec_o.pc_to_reg,
                             id_dec_o.rd_src, id_dec_o.mem_to_reg},
                            {e.dec.illegal, e.dec.reg_write,
                             e.dec.mem_write, e.dec.mem_read,
                             e.dec.pc_src, e.dec.pc_to_reg,
                             e.dec.rd_src, e.dec.mem_to_reg});
                        sb.delete();
                    end else begin
                        chk("out_dec", id_dec_o, e.dec);
                    end
                end
            end
            if (flush_i === 1'b1) sb.delete();
            if (if_valid_i && if_ready_o === 1'b1 && !flush_i) begin
                sb_t n;
                n.pc  = if_pc_i;
                n.dec = drv_exp;
                sb.push_back(n);
            end
        end
    end

    task automatic offer(input logic [31:0] pc, input int vi, output bit acc);
        @(posedge clk);
        #1;
        if_valid_i = 1'b1;
        if_pc_i    = pc;
        if_instr_i = tbl[vi].instr;
        drv_exp    = tbl[vi].exp;
        @(negedge clk);
        acc = (if_ready_o === 1'b1);
        @(posedge clk);
        #1;
        if_valid_i = 1'b0;
    endtask

    task automatic send(input logic [31:0] pc, input int vi);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            offer(pc, vi, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept, expected accept pc 0x%0h", pc);
        end
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(name, sb.size(), 0);
    endtask

    task automatic pulse_flush();
        @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int nacc;
        int cyc;
        int p0;

        tbl[0]  = mk(32'hFFB10093, IMM_I, 32'hFFFFFFFB, 4'b0000, 2'b00, 7'b0000001, 3'b000);
        tbl[1]  = mk(32'h40315093, IMM_I, 32'h00000403, 4'b1101, 2'b00, 7'b0000001, 3'b000);
        tbl[2]  = mk(32'h001000EF, IMM_J, 32'h00000800, 4'b1011, 2'b01, 7'b0001001, 3'b000);
        tbl[3]  = mk(32'h002081B3, IMM_NONE, 32'h0, 4'b0000, 2'b00, 7'b0000011, 3'b000);
        tbl[4]  = mk(32'h402081B3, IMM_NONE, 32'h0, 4'b1000, 2'b00, 7'b0000011, 3'b000);
        tbl[5]  = mk(32'h0080A283, IMM_I, 32'h00000008, 4'b0000, 2'b00, 7'b0010101, 3'b010);
        tbl[6]  = mk(32'hFE50AE23, IMM_S, 32'hFFFFFFFC, 4'b0000, 2'b00, 7'b0100000, 3'b010);
        tbl[7]  = mk(32'hFE208CE3, IMM_B, 32'hFFFFFFF8, 4'b1000, 2'b11, 7'b0000000, 3'b000);
        tbl[8]  = mk(32'h000280E7, IMM_I, 32'h00000000, 4'b0000, 2'b10, 7'b0001001, 3'b000);
        tbl[9]  = mk(32'h123453B7, IMM_U, 32'h12345000, 4'b1011, 2'b00, 7'b0000001, 3'b000);
        tbl[10] = mk(32'hFFFFF397, IMM_U, 32'hFFFFF000, 4'b0000, 2'b00, 7'b1001001, 3'b000);
        tbl[11] = mkill(32'h00000000);
        tbl[12] = mkill(32'h402091B3);
        tbl[13] = mkill(32'h0020A063);
        tbl[14] = mk(32'h0000C283, IMM_I, 32'h00000000, 4'b0000, 2'b00, 7'b0010101, 3'b100);
        tbl[15] = mkill(32'h0000B283);
        tbl[16] = mkill(32'h40109093);

        // Reset with a pending fetch word
        rst        = 1'b0;
        flush_i    = 1'b0;
        id_ready_i = 1'b0;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h50;
        if_instr_i = tbl[0].instr;
        drv_exp    = tbl[0].exp;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_if_ready", if_ready_o, 0);
            chk("rst_id_valid", id_valid_o, 0);
        end
        chk("rst_dec", id_dec_o, 0);
        chk("rst_pc", id_pc_o, 0);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        if_valid_i = 1'b0;
        id_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_nothing_queued", id_valid_o, 0);
        chk("run_if_ready", if_ready_o, 1);

        // Decode table, one word at a time
        for (int i = 0; i < 17; i++) begin
            send(32'h100 + 32'(4 * i), i);
            if (i == 0) begin
                @(negedge clk);
                chk("lat_edge1", id_valid_o, 0);
                @(negedge clk);
                chk("lat_edge2", id_valid_o, 1);
            end
            wait_drain("vec_drain");
            if (tbl[i].exp.illegal) begin
                chk("halt_if_ready", if_ready_o, 0);
                pulse_flush();
                @(negedge clk);
                chk("resume_if_ready", if_ready_o, 1);
            end
        end

        // Capacity: QDEPTH plus the output register
        @(posedge clk);
        #1;
        id_ready_i = 1'b0;
        nacc = 0;
        for (int k = 0; k < 6; k++) begin
            offer(32'h200 + 32'(4 * k), 3 + k, acc);
            if (acc) nacc++;
        end
        chk("cap_accepted", nacc, 5);
        chk("cap_if_ready", if_ready_o, 0);
        p0 = pops;
        id_ready_i = 1'b1;
        cyc = 0;
        while (sb.size() != 0 && cyc < 20) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("cap_drain_cycles", cyc, 5);
        chk("cap_pops", pops - p0, 5);

        // Illegal word halts fetch and drops the words behind it
        @(posedge clk);
        #1;
        id_ready_i = 1'b0;
        offer(32'h300, 11, acc);
        chk("ill_acc0", acc, 1);
        offer(32'h304, 0, acc);
        offer(32'h308, 3, acc);
        chk("halt_refuse", acc, 0);
        @(negedge clk);
        chk("ill_valid", id_valid_o, 1);
        chk("ill_flag", id_dec_o.illegal, 1);
        chk("ill_wr", {id_dec_o.reg_write, id_dec_o.mem_write}, 0);
        chk("ill_if_ready", if_ready_o, 0);
        @(posedge clk);
        #1;
        id_ready_i = 1'b1;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            chk("ill_discard", id_valid_o, 0);
            chk("ill_halted", if_ready_o, 0);
        end
        pulse_flush();
        @(negedge clk);
        chk("ill_resume", if_ready_o, 1);
        send(32'h310, 9);
        wait_drain("ill_after_drain");

        // Flush with a fetch word, a full output and a queued word
        @(posedge clk);
        #1;
        id_ready_i = 1'b0;
        offer(32'h400, 3, acc);
        offer(32'h404, 4, acc);
        @(posedge clk);
        #1;
        flush_i    = 1'b1;
        id_ready_i = 1'b1;
        if_valid_i = 1'b1;
        if_pc_i    = 32'h408;
        if_instr_i = tbl[5].instr;
        drv_exp    = tbl[5].exp;
        p0 = pops;
        @(posedge clk);
        #1;
        flush_i    = 1'b0;
        if_valid_i = 1'b0;
        chk("flush_xfer", pops - p0, 1);
        @(negedge clk);
        chk("flush_valid", id_valid_o, 0);
        repeat (2) @(negedge clk);
        chk("flush_dropped", id_valid_o, 0);
        offer(32'h40C, 10, acc);
        @(negedge clk);
        chk("post_flush_lat1", id_valid_o, 0);
        @(negedge clk);
        chk("post_flush_lat2", id_valid_o, 1);
        wait_drain("post_flush_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
